// File: rtl/hc595_rx.sv
// 74HC595 link receiver: rebuilds sel/seg from ds/shcp/stcp/oe.
// Ports: sys_clk, sys_rst_n, ds, shcp, stcp, oe -> sel, seg, frame_vld, frame_err, frame_cnt.
module hc595_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        oe,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_vld,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]  pins;
  logic [3:0]  s;
  logic        shcp_q;
  logic        stcp_q;
  logic        shift;
  logic        latch;
  logic [13:0] sr;
  logic [13:0] st;
  logic [3:0]  bit_cnt;

  assign pins = {oe, stcp, shcp, ds};
  assign s    = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      shcp_q <= 1'b0;
      stcp_q <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      shcp_q <= s[1];
      stcp_q <= s[2];
    end
  end

  // ds shares the sync depth with shcp, so s[0] is the bit
  // that was on the pin when shcp rose.
  assign shift = s[1] & ~shcp_q;
  assign latch = s[2] & ~stcp_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr        <= '0;
      st        <= '0;
      bit_cnt   <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_vld <= latch;
      if (shift)
        sr <= {sr[12:0], s[0]};
      if (latch) begin
        // st takes the pre-shift sr on a coincident edge
        st        <= sr;
        frame_err <= (bit_cnt != 4'(FRAME_BITS));
        frame_cnt <= frame_cnt + 16'd1;
      end
      // a bit shifted with the latch belongs to the next frame
      if (shift) begin
        if (latch)
          bit_cnt <= 4'd1;
        else if (bit_cnt != 4'd15)
          bit_cnt <= bit_cnt + 4'd1;
      end else if (latch) begin
        bit_cnt <= '0;
      end
    end
  end

  // first-shifted bit lands in st[13] and is sel[0]
  always_comb begin
    sel = '0;
    seg = '0;
    if (!s[3]) begin
      for (int i = 0; i < 6; i++)
        sel[i] = st[13-i];
      seg = st[7:0];
    end
  end

endmodule

// File: tb/tb_hc595_rx.sv
// Bench for hc595_rx: frame-level model checked every cycle.
// Directed frames cover order, count errors, coincident edges, oe, reset.
module tb_hc595_rx;
  localparam int SS = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        ds, shcp, stcp, oe;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_vld, frame_err;
  logic [15:0] frame_cnt;

  hc595_rx #(.SYNC_STAGES(SS), .FRAME_BITS(14)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .sel(sel), .seg(seg),
    .frame_vld(frame_vld), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    logic       err;
    int         due;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   hist[$];
  int   nb = 0;
  exp_t pend[$];
  logic [5:0]  m_sel = '0;
  logic [7:0]  m_seg = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = '0;
  logic oe_pin_m = 1'b0;
  logic oe_prev = 1'b0;
  int   oe_chg = -100;

  logic [7:0] code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always @(posedge sys_clk) cyc++;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    logic ev;
    logic oe_eff;
    exp_t e;
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    if (ev) begin
      e = pend.pop_front();
      m_sel = e.sel;
      m_seg = e.seg;
      m_err = e.err;
      m_cnt = m_cnt + 16'd1;
    end
    oe_eff = (cyc - oe_chg >= SS) ? oe_pin_m : oe_prev;
    chk("vld", 16'(frame_vld), 16'(ev));
    chk("err", 16'(frame_err), 16'(m_err));
    chk("cnt", frame_cnt, m_cnt);
    chk("sel", 16'(sel), oe_eff ? 16'h0 : 16'(m_sel));
    chk("seg", 16'(seg), oe_eff ? 16'h0 : 16'(m_seg));
  end

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic exp_t frame_of(int due);
    exp_t e;
    int   n;
    bit   b [14];
    n = hist.size();
    for (int k = 0; k < 14; k++)
      b[k] = (n - 14 + k >= 0) ? hist[n-14+k] : 1'b0;
    for (int i = 0; i < 6; i++) e.sel[i] = b[i];
    for (int m = 0; m < 8; m++) e.seg[7-m] = b[6+m];
    e.err = (nb != 14);
    e.due = due;
    return e;
  endfunction

  task automatic shift(bit b);
    ds = b;
    tick(2);
    shcp = 1'b1;
    tick(2);
    shcp = 1'b0;
    hist.push_back(b);
    nb++;
  endtask

  task automatic latch();
    stcp = 1'b1;
    pend.push_back(frame_of(cyc + SS + 1));
    nb = 0;
    tick(2);
    stcp = 1'b0;
    tick(2);
  endtask

  task automatic shift_latch(bit b);
    ds = b;
    tick(2);
    shcp = 1'b1;
    stcp = 1'b1;
    pend.push_back(frame_of(cyc + SS + 1));
    nb = 0;
    hist.push_back(b);
    nb++;
    tick(2);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(2);
  endtask

  function automatic bit fbit(logic [5:0] s6, logic [7:0] s8, int k);
    return (k < 6) ? s6[k] : s8[13-k];
  endfunction

  task automatic send(logic [5:0] s6, logic [7:0] s8, int from, int upto);
    for (int k = from; k < upto; k++) shift(fbit(s6, s8, k));
  endtask

  task automatic set_oe(logic v);
    oe_prev = (cyc - oe_chg >= SS) ? oe_pin_m : oe_prev;
    oe = v;
    oe_pin_m = v;
    oe_chg = cyc;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    hist.delete();
    pend.delete();
    nb = 0;
    m_sel = '0;
    m_seg = '0;
    m_err = 1'b0;
    m_cnt = '0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    ds = 0; shcp = 0; stcp = 0; oe = 0;
    sys_rst_n = 1'b0;
    tick(1);
    chk("rst_cnt", frame_cnt, 16'h0);
    chk("rst_seg", 16'(seg), 16'h0);
    do_reset();

    // directed frame
    send(6'b111110, 8'hA4, 0, 14);
    latch();
    chk("dir_sel", 16'(sel), 16'h003E);
    chk("dir_seg", 16'(seg), 16'h00A4);
    chk("dir_err", 16'(frame_err), 16'h0);
    chk("dir_cnt", frame_cnt, 16'h1);

    // short then full frame
    do_reset();
    send(6'b101111, 8'h92, 0, 13);
    latch();
    chk("short_err", 16'(frame_err), 16'h1);
    send(6'b011111, 8'hF8, 0, 14);
    latch();
    chk("full_err", 16'(frame_err), 16'h0);
    chk("full_cnt", frame_cnt, 16'h2);
    chk("full_seg", 16'(seg), 16'h00F8);

    // coincident shcp/stcp rise
    do_reset();
    send(6'b110111, 8'hB0, 0, 14);
    shift_latch(fbit(6'b111011, 8'h80, 0));
    chk("sim_sel", 16'(sel), 16'h0037);
    chk("sim_seg", 16'(seg), 16'h00B0);
    chk("sim_err", 16'(frame_err), 16'h0);
    send(6'b111011, 8'h80, 1, 14);
    latch();
    chk("sim2_err", 16'(frame_err), 16'h0);
    chk("sim2_seg", 16'(seg), 16'h0080);

    // oe gating
    do_reset();
    send(6'b111101, 8'h99, 0, 14);
    latch();
    set_oe(1'b1);
    tick(4);
    chk("oe_sel", 16'(sel), 16'h0);
    chk("oe_seg", 16'(seg), 16'h0);
    set_oe(1'b0);
    tick(4);
    chk("oe_back", 16'(seg), 16'h0099);

    // overrun and empty frame
    do_reset();
    shift(1'b1);
    shift(1'b0);
    send(6'b111110, 8'hC0, 0, 14);
    latch();
    chk("ovr_err", 16'(frame_err), 16'h1);
    chk("ovr_seg", 16'(seg), 16'h00C0);
    latch();
    chk("empty_err", 16'(frame_err), 16'h1);
    chk("empty_seg", 16'(seg), 16'h00C0);

    // reset mid-frame
    do_reset();
    send(6'b101010, 8'h55, 0, 7);
    sys_rst_n = 1'b0;
    hist.delete(); pend.delete(); nb = 0;
    m_sel = '0; m_seg = '0; m_err = 1'b0; m_cnt = '0;
    #1;
    chk("mid_sel", 16'(sel), 16'h0);
    chk("mid_seg", 16'(seg), 16'h0);
    chk("mid_cnt", frame_cnt, 16'h0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);
    send(6'b011111, 8'h90, 0, 14);
    latch();
    chk("mid2_seg", 16'(seg), 16'h0090);
    chk("mid2_err", 16'(frame_err), 16'h0);
    chk("mid2_cnt", frame_cnt, 16'h1);

    // display-driver style scan of 123456
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int d;
      d = (123456 / (10 ** i)) % 10;
      send(~(6'b1 << i), code[d], 0, 14);
      latch();
      if (i == 0) chk("scan_seg0", 16'(seg), 16'h0082);
      if (i == 5) chk("scan_seg5", 16'(seg), 16'h00F9);
    end
    chk("scan_cnt", frame_cnt, 16'h6);

    tick(5);
    chk("pend_empty", 16'(pend.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc595_rx.md
Name: hc595_rx

Overview:
- RTL receiver for the 74HC595 serial display link: ds, shcp, stcp, oe.
- Behaves as the far end of the shift/latch stream: shifts ds on shcp rising edges and copies the shift register to a storage register on stcp rising edges.
- Delivers the reconstructed digit-select and segment bytes with a per-frame valid/error indication.
- Used as an on-chip loopback checker for the segment display path, and as the display model in the display-path testbench.

Parameters:
- SYNC_STAGES, 2, input synchronizer depth applied identically to ds, shcp, stcp and oe (min 1).
- FRAME_BITS, 14, expected shcp rising edges per stcp latch (6 select + 8 segment bits).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- ds  input  1  serial data, sampled on shcp rising edge.
- shcp  input  1  shift clock; treated as data and edge-detected in sys_clk.
- stcp  input  1  storage latch clock; treated as data and edge-detected in sys_clk.
- oe  input  1  active-low output enable.
- sel  output  6  latched digit select; 0 while oe is high.
- seg  output  8  latched segment pattern; 0 while oe is high.
- frame_vld  output  1  one-cycle pulse when a latch occurs.
- frame_err  output  1  qualifies frame_vld; 1 = latch occurred with bit count != FRAME_BITS.
- frame_cnt  output  16  number of latches since reset, wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): all of the following are 0 — synchronizers, shift register sr[13:0], storage register st[13:0], bit_cnt, sel, seg, frame_vld, frame_err, frame_cnt.
- Synchronizers:
  - All four inputs pass through SYNC_STAGES flops.
  - shcp and stcp then go through one further flop for edge detection: rise = cur & ~prev.
  - The ds sample taken is the synchronized ds in the same cycle as the shcp rise; both paths have equal depth, so ds must be stable at the shcp rising edge, as the transmitter guarantees.
- Input timing: shcp and stcp high and low times each >= 2 sys_clk. The transmitter's 4-clock shcp period meets this.
- Shift, on shcp rise:
  - sr <= {sr[12:0], ds_sync}.
  - bit_cnt <= bit_cnt + 1, saturating at 15 (4-bit counter).
- Frame bit order, as b0..b13 in shift order:
  - b0..b5 = sel[0]..sel[5].
  - b6..b13 = seg[7]..seg[0].
  - After 14 shifts, sr[13] = b0. Output mapping: sel[i] = st[13-i]; seg[j] = st[j].
- Latch, on stcp rise:
  - st <= sr.
  - frame_vld = 1 for exactly one cycle.
  - frame_err = (bit_cnt != FRAME_BITS), held until the next latch.
  - frame_cnt increments.
  - bit_cnt <= 0; sr is NOT cleared, matching the real device.
- Latency: stcp edge at the pin -> frame_vld high and sel/seg updated SYNC_STAGES+1 sys_clk later.
- Simultaneous shcp and stcp rise in the same cycle:
  - st takes the pre-shift sr.
  - The shift still occurs.
  - bit_cnt becomes 1, not 0 — the new bit counts toward the next frame.
  - frame_err is evaluated on the pre-shift count.
- Outputs: sel/seg are combinational from st, gated by the synchronized oe (oe_sync=1 -> both 0). Gating does not affect st, frame_vld or frame_err.
- Boundary cases:
  - Overrun: >15 shifts -> bit_cnt saturates, sr holds the last 14 bits, frame_err on the next latch.
  - Empty frame: stcp with 0 shifts -> st reloads unchanged sr, frame_err=1.
  - Reset mid-frame: everything cleared; the partial frame is discarded.
- No other sequential state; no handshake back to the transmitter.

Test Plan:
- Loopback with display driver, data=20'd123456, point=0, sign=0, seg_en=1:
  - frame_err stays 0.
  - Each frame_vld shows a one-hot-low sel cycling 6 values; seg equals the segment code for that digit (e.g. 8'hC0 for '0' where displayed).
- Directed frame, sel=6'b111110, seg=8'hA4, 14 shifts then stcp:
  - sel=6'b111110, seg=8'hA4, frame_vld 1 cycle, frame_err=0, latency SYNC_STAGES+1 from the stcp edge.
- 13 shifts then stcp -> frame_err=1. Then 14 shifts then stcp -> frame_err=0, frame_cnt=2.
- shcp and stcp rise together after 14 prior shifts:
  - st equals the 14-bit frame without the new bit.
  - Next frame of 13 further shifts -> frame_err=0 (bit_cnt=14).
- oe driven high after a latch of seg=8'h99 -> sel=0, seg=0. oe low -> seg=8'h99 reappears, no frame_vld.
- sys_rst_n pulsed low after 7 shifts -> all outputs 0. Full 14-bit frame afterwards -> correct data, frame_err=0, frame_cnt=1.
